// File: rtl/fifo.sv
// fifo: 8x8 single-clock FIFO; clk, active-low async rst, wr/rd strobes, data_in -> data_out, empty/full/fifo_cnt
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   fifo_cnt
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_ok, rd_ok;
  always_comb begin
    empty = fifo_cnt == '0;
    full  = fifo_cnt == (ADDR_WIDTH+1)'(DEPTH);
    wr_ok = wr & ~full;
    rd_ok = rd & ~empty;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      fifo_cnt <= fifo_cnt + {{ADDR_WIDTH{1'b0}}, wr_ok} - {{ADDR_WIDTH{1'b0}}, rd_ok};
    end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: table-driven, directed and random checks of fifo against a queue model
module tb_fifo;
  logic       clk = 0, rst = 0, wr = 0, rd = 0;
  logic [7:0] data_in = 0, data_out;
  logic       empty, full;
  logic [3:0] fifo_cnt;
  int         checks = 0, failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_dout = 0;

  fifo dut (.clk(clk), .rst(rst), .wr(wr), .rd(rd), .data_in(data_in),
            .data_out(data_out), .empty(empty), .full(full), .fifo_cnt(fifo_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    int         dout;
    logic       emp;
    logic       ful;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, e);
    end
  endtask

  task automatic chk_model(input string n);
    chk({n, "_cnt"}, int'(fifo_cnt), q.size());
    chk({n, "_empty"}, int'(empty), int'(q.size() == 0));
    chk({n, "_full"}, int'(full), int'(q.size() == 8));
    chk({n, "_dout"}, int'(data_out), int'(exp_dout));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit wok, rok;
    wr = w; rd = r; data_in = d;
    @(posedge clk);
    wok = w && q.size() < 8;
    rok = r && q.size() > 0;
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(d);
    #1;
    wr = 0; rd = 0;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_cnt"}, int'(fifo_cnt), 0);
    chk({n, "_empty"}, int'(empty), 1);
    chk({n, "_full"}, int'(full), 0);
    chk({n, "_dout"}, int'(data_out), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vt[i] = '{1, 0, 8'(i + 1), i + 1, 0, 0, i == 7};
    vt[8] = '{1, 0, 8'hFF, 8, 0, 0, 1};
    for (int i = 0; i < 8; i++) vt[9 + i] = '{0, 1, 8'h00, 7 - i, i + 1, i == 7, 0};
    vt[17] = '{0, 1, 8'h00, 0, 8, 1, 0};

    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    rst = 1;

    for (int i = 0; i < 18; i++) begin
      step(vt[i].w, vt[i].r, vt[i].d);
      chk($sformatf("vec%0d_cnt", i), int'(fifo_cnt), vt[i].cnt);
      chk($sformatf("vec%0d_dout", i), int'(data_out), vt[i].dout);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].emp));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vt[i].ful));
    end

    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("wrap_rd3", int'(data_out), 8'h12);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h20 + i));
    chk("wrap_cnt8", int'(fifo_cnt), 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk_model($sformatf("wrap_rd%0d", i));
    end

    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'(8'h40 + i));
      chk($sformatf("sim4_cnt%0d", i), int'(fifo_cnt), 4);
      chk($sformatf("sim4_dout%0d", i), int'(data_out), 8'h30 + i);
    end
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h50 + i));
    chk("full_before", int'(full), 1);
    step(1, 1, 8'hEE);
    chk("simfull_cnt", int'(fifo_cnt), 7);
    chk("simfull_dout", int'(data_out), 8'h33);
    while (q.size() > 0) begin
      step(0, 1, 0);
      chk_model("simfull_drain");
      chk("no_ee", int'(data_out == 8'hEE), 0);
    end

    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i));
    step(0, 1, 0);
    step(1, 0, 8'h70);
    #3 rst = 0;
    #1 chk_reset("async_rst");
    q.delete();
    exp_dout = 0;
    @(posedge clk);
    #1 rst = 1;

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      chk_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
